// File: rtl/tone_scheduler_if.sv
// Beeper control bundle between the game FSM and tone_scheduler.
// master drives config/timebase, slave is the scheduler.
interface tone_scheduler_if;
  logic        timebase;
  logic        enable;
  logic        cfg_load;
  logic [9:0]  tph_in;
  logic [9:0]  freq_in;
  logic        busy;
  logic        cfg_ack;
  logic        beep_active;
  logic        tone_out;
  logic [21:0] interval_ms;
  logic [15:0] tone_count;

  modport master (
    output timebase, enable, cfg_load,
    output tph_in, freq_in,
    input  busy, cfg_ack, beep_active,
    input  tone_out, interval_ms, tone_count
  );

  modport slave (
    input  timebase, enable, cfg_load,
    input  tph_in, freq_in,
    output busy, cfg_ack, beep_active,
    output tone_out, interval_ms, tone_count
  );
endinterface

// File: rtl/tone_scheduler.sv
// Periodic beeper scheduler: rate -> interval via sequential divide,
// then WAIT/TONE cycling on the ms timebase with a phase-accumulator tone.
module tone_scheduler #(
  parameter int unsigned PHASE_STEP = 4295,
  parameter int unsigned TONE_MS    = 200,
  parameter int unsigned DIVIDEND   = 3600000
) (
  input  logic             clk,
  input  logic             reset,
  tone_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WAIT,
    TONE
  } state_t;

  localparam logic [21:0] DVD  = 22'(DIVIDEND);
  localparam logic [21:0] TMS  = 22'(TONE_MS);
  localparam logic [12:0] STEP = 13'(PHASE_STEP);

  state_t      state_q, state_d;
  logic [9:0]  tph_q, tph_d;
  logic [9:0]  freq_q, freq_d;
  logic [21:0] dvd_q, dvd_d;
  logic [9:0]  rem_q, rem_d;
  logic [21:0] quo_q, quo_d;
  logic [4:0]  iter_q, iter_d;
  logic [21:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [21:0] ival_q, ival_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        ack_q, ack_d;

  logic        accept;
  logic        valid;
  logic [10:0] trial;
  logic [10:0] diff;
  logic        ge;
  logic [9:0]  rem_nx;
  logic [21:0] quo_nx;
  logic [22:0] prod;

  assign accept = bus.cfg_load && (state_q != CALC);
  assign valid  = (tph_q != 10'd0) && (freq_q != 10'd0);

  // One restoring step: remainder stays below tph so 10 bits suffice.
  assign trial  = {rem_q, dvd_q[21]};
  assign diff   = trial - {1'b0, tph_q};
  assign ge     = trial >= {1'b0, tph_q};
  assign rem_nx = ge ? diff[9:0] : trial[9:0];
  assign quo_nx = {quo_q[20:0], ge};

  assign prod   = freq_q * STEP;

  always_comb begin
    state_d = state_q;
    tph_d   = tph_q;
    freq_d  = freq_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ival_d  = ival_q;
    tcnt_d  = tcnt_q;
    ack_d   = 1'b0;

    if (accept) begin
      tph_d   = bus.tph_in;
      freq_d  = bus.freq_in;
      dvd_d   = DVD;
      rem_d   = 10'd0;
      quo_d   = 22'd0;
      iter_d  = 5'd0;
      state_d = CALC;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.enable && valid) begin
            state_d = WAIT;
            cnt_d   = ival_q - TMS;
          end
        end
        CALC: begin
          if (tph_q == 10'd0) begin
            ival_d  = 22'd0;
            ack_d   = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d  = rem_nx;
            quo_d  = quo_nx;
            dvd_d  = {dvd_q[20:0], 1'b0};
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd21) begin
              ival_d = quo_nx;
              ack_d  = 1'b1;
              if (bus.enable && freq_q != 10'd0) begin
                state_d = WAIT;
                cnt_d   = quo_nx - TMS;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        WAIT: begin
          if (!bus.enable) begin
            state_d = IDLE;
          end else if (bus.timebase) begin
            if (cnt_q == 22'd1) begin
              state_d = TONE;
              cnt_d   = TMS;
              acc_d   = 32'd0;
              tcnt_d  = tcnt_q + 16'd1;
            end else begin
              cnt_d = cnt_q - 22'd1;
            end
          end
        end
        TONE: begin
          if (!bus.enable) begin
            state_d = IDLE;
          end else begin
            acc_d = acc_q + {9'd0, prod};
            if (bus.timebase) begin
              if (cnt_q == 22'd1) begin
                state_d = WAIT;
                cnt_d   = ival_q - TMS;
              end else begin
                cnt_d = cnt_q - 22'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tph_q   <= '0;
      freq_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ival_q  <= '0;
      tcnt_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tph_q   <= tph_d;
      freq_q  <= freq_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ival_q  <= ival_d;
      tcnt_q  <= tcnt_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.cfg_ack     = ack_q;
  assign bus.beep_active = (state_q == TONE);
  assign bus.tone_out    = (state_q == TONE) && acc_q[31];
  assign bus.interval_ms = ival_q;
  assign bus.tone_count  = tcnt_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: divider vectors,
// burst timing, pitch, mid-burst controls, enable and reset.
module tb_tone_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tone_scheduler_if bus ();

  tone_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int tph;
    int freq;
    int iv;
    int nb;
  } vec_t;

  typedef struct {
    int iv;
    int nb;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_tog = -1;
  int hp_min = 0;
  int hp_max = 0;
  int tog_cnt = 0;
  int out_leak = 0;
  logic prev_tone = 1'b0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_rng(input string name, input int got,
                           input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic int exp_iv(input int t);
    return (t == 0) ? 0 : 3600000 / t;
  endfunction

  task automatic tick(input bit tbv);
    bus.timebase = tbv;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.beep_active && bus.tone_out !== prev_tone) begin
      if (last_tog >= 0) begin
        if (cyc - last_tog < hp_min) hp_min = cyc - last_tog;
        if (cyc - last_tog > hp_max) hp_max = cyc - last_tog;
      end
      last_tog = cyc;
      tog_cnt++;
    end
    if (bus.tone_out && !bus.beep_active) out_leak++;
    prev_tone = bus.tone_out;
  endtask

  task automatic do_load(input int tph, input int freq, input int iv);
    bus.tph_in   = 10'(tph);
    bus.freq_in  = 10'(freq);
    bus.cfg_load = 1'b1;
    tick(1'b0);
    bus.cfg_load = 1'b0;
    sb.push_back('{iv: iv, nb: (tph == 0) ? 1 : 22});
  endtask

  task automatic wait_ack(input int inject_at);
    int nb;
    int k;
    exp_t e;
    nb = 0;
    k  = 0;
    while (!bus.cfg_ack && k < 60) begin
      if (bus.busy) nb++;
      if (k == inject_at) begin
        bus.tph_in   = 10'd3;
        bus.freq_in  = 10'd7;
        bus.cfg_load = 1'b1;
      end
      tick(1'b0);
      bus.cfg_load = 1'b0;
      k++;
    end
    check("cfg_ack_seen", bus.cfg_ack, 1);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("interval_ms", bus.interval_ms, e.iv);
      check("busy_clks", nb, e.nb);
    end
    tick(1'b0);
    check("cfg_ack_one_clk", bus.cfg_ack, 0);
  endtask

  task automatic wait_level(input bit want, input int div,
                            input int limit, output int ticks);
    int k;
    bit p;
    k = 0;
    ticks = 0;
    while (bus.beep_active !== want && k < limit) begin
      p = (div <= 1) || (k % div == div - 1);
      tick(p);
      if (p) ticks++;
      k++;
    end
    check("beep_level_reached", bus.beep_active, want);
    if (want) begin
      last_tog = cyc;
      hp_min   = 1 << 30;
      hp_max   = 0;
      tog_cnt  = 0;
    end
  endtask

  task automatic wait_tone_high();
    int k;
    k = 0;
    while (!bus.tone_out && k < 2000) begin
      tick(k % 16 == 15);
      k++;
    end
    check("tone_out_high", bus.tone_out, 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    tick(1'b0);
    sb.delete();
  endtask

  initial begin
    int t;
    int blen;
    int tc0;
    int seen;
    reset        = 1'b1;
    bus.timebase = 1'b0;
    bus.enable   = 1'b0;
    bus.cfg_load = 1'b0;
    bus.tph_in   = 10'd0;
    bus.freq_in  = 10'd0;

    vt = '{
      '{tph: 250, freq: 500, iv: 14400,   nb: 22},
      '{tph: 999, freq: 500, iv: 3603,    nb: 22},
      '{tph: 1,   freq: 500, iv: 3600000, nb: 22},
      '{tph: 0,   freq: 500, iv: 0,       nb: 1},
      '{tph: 7,   freq: 1,   iv: 514285,  nb: 22},
      '{tph: 512, freq: 999, iv: 7031,    nb: 22},
      '{tph: 360, freq: 0,   iv: 10000,   nb: 22},
      '{tph: 998, freq: 3,   iv: 3607,    nb: 22}
    };

    tick(1'b0);
    tick(1'b0);
    check("reset_outputs",
          {bus.busy, bus.cfg_ack, bus.beep_active, bus.tone_out,
           bus.interval_ms, bus.tone_count}, 0);
    reset = 1'b0;
    tick(1'b0);
    check("post_reset_outputs",
          {bus.busy, bus.cfg_ack, bus.beep_active, bus.tone_out,
           bus.interval_ms, bus.tone_count}, 0);

    // divider vectors
    for (int i = 0; i < 8; i++) begin
      do_load(vt[i].tph, vt[i].freq, vt[i].iv);
      check("busy_after_load", bus.busy, 1);
      sb[sb.size() - 1].nb = vt[i].nb;
      wait_ack(-1);
    end

    // tph = 0 with enable: stays idle, no tone
    bus.enable = 1'b1;
    do_load(0, 500, exp_iv(0));
    wait_ack(-1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (bus.beep_active || bus.tone_out) seen++;
    end
    check("tph0_no_tone", seen, 0);
    bus.enable = 1'b0;

    // first burst after configuration
    apply_reset();
    bus.enable = 1'b1;
    do_load(250, 500, exp_iv(250));
    wait_ack(-1);
    wait_level(1'b1, 1, 20000, t);
    check("first_burst_ticks", t, 14200);
    check("tone_count_1", bus.tone_count, 1);
    wait_level(1'b0, 1, 1000, t);
    check("burst_len_fast", t, 200);

    // spacing and pitch over three bursts
    do_load(999, 500, exp_iv(999));
    wait_ack(-1);
    tc0  = int'(bus.tone_count);
    blen = 0;
    for (int b = 0; b < 3; b++) begin
      wait_level(1'b1, 1, 5000, t);
      if (b == 0) check("wait_ticks", t, 3403);
      else check("start_to_start", t + blen, 3603);
      wait_level(1'b0, 16, 5000, blen);
      check("burst_len", blen, 200);
      check_rng("half_period_min", hp_min, 999, 1001);
      check_rng("half_period_max", hp_max, 999, 1001);
      check_rng("toggles", tog_cnt, 2, 4);
    end
    check("tone_count_3_more", bus.tone_count, tc0 + 3);

    // cfg_load mid-burst, plus an ignored load while busy
    wait_level(1'b1, 1, 5000, t);
    wait_tone_high();
    do_load(500, 500, exp_iv(500));
    check("tone_out_drop", bus.tone_out, 0);
    check("beep_drop", bus.beep_active, 0);
    check("busy_mid_burst", bus.busy, 1);
    wait_ack(5);
    wait_level(1'b1, 1, 9000, t);
    check("new_interval_used", t, 7000);
    wait_level(1'b0, 1, 1000, t);

    // enable drop mid-WAIT, then re-raise
    for (int i = 0; i < 1000; i++) tick(1'b1);
    bus.enable = 1'b0;
    tick(1'b0);
    tc0  = int'(bus.tone_count);
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1'b1);
      if (bus.beep_active) seen++;
    end
    check("disabled_no_beep", seen, 0);
    check("disabled_count_held", bus.tone_count, tc0);
    bus.enable = 1'b1;
    tick(1'b0);
    wait_level(1'b1, 1, 9000, t);
    check("reenable_full_wait", t, 7000);

    // asynchronous reset mid-TONE
    wait_tone_high();
    #2 reset = 1'b1;
    #1;
    check("areset_tone_count", bus.tone_count, 0);
    check("areset_tone_out", bus.tone_out, 0);
    check("areset_beep", bus.beep_active, 0);
    check("areset_interval", bus.interval_ms, 0);
    tick(1'b0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b1);
      if (bus.beep_active || bus.busy) seen++;
    end
    check("config_lost_idle", seen, 0);

    // asynchronous reset mid-CALC
    do_load(250, 500, exp_iv(250));
    for (int i = 0; i < 5; i++) tick(1'b0);
    #2 reset = 1'b1;
    #1;
    check("areset_busy", bus.busy, 0);
    tick(1'b0);
    reset = 1'b0;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0);
      if (bus.cfg_ack || bus.busy) seen++;
    end
    check("calc_aborted_by_reset", seen, 0);
    check("interval_after_reset", bus.interval_ms, 0);

    check("tone_out_outside_tone", out_leak, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
